e203_exu_wfi_ctrl: RTL and testbench

Sequencer for the WFI (wait-for-interrupt) halt handshake in the EXU commit stage. Once a WFI commits, it drains outstanding long-pipe work and waits out any pending pipeline flush. It then asks the IFU and EXU to halt, and reports the core asleep once both acknowledge. It releases the halt on any enabled wake source. Its `wfi_halt_*_req` outputs are the signals that must stay one-hot-0 against `pipe_flush_req`.

---
 rtl/e203_exu_wfi_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_e203_exu_wfi_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_wfi_ctrl.sv
// WFI halt-handshake sequencer: drain long-pipe work, request IFU/EXU halt, sleep until a wake source fires.
// Optional E203_WFI_EVT_WAKE_EN adds |evt_r as an extra wake term.
`ifndef E203_LIRQ_NUM
`define E203_LIRQ_NUM 1
`endif
`ifndef E203_EVT_NUM
`define E203_EVT_NUM 1
`endif

module e203_exu_wfi_ctrl #(
    parameter int LIRQ_NUM = `E203_LIRQ_NUM,
    parameter int EVT_NUM  = `E203_EVT_NUM,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wfi_cmt,
    input  logic                dbg_mode,
    input  logic                dbg_halt_r,
    input  logic                dbg_irq_r,
    input  logic                ext_irq_r,
    input  logic                sft_irq_r,
    input  logic                tmr_irq_r,
    input  logic                meie_r,
    input  logic                msie_r,
    input  logic                mtie_r,
    input  logic [LIRQ_NUM-1:0] lcl_irq_r,
    input  logic [EVT_NUM-1:0]  evt_r,
    input  logic                oitf_empty,
    input  logic                pipe_flush_req,
    output logic                wfi_halt_ifu_req,
    output logic                wfi_halt_exu_req,
    input  logic                wfi_halt_ifu_ack,
    input  logic                wfi_halt_exu_ack,
    output logic                core_wfi,
    output logic                wfi_busy,
    output logic                wfi_wake,
    output logic [CNT_W-1:0]    sleep_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_REQ   = 2'd2,
        ST_SLEEP = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             ifu_ack_q, ifu_ack_d;
    logic             exu_ack_q, exu_ack_d;
    logic             ifu_req_q, ifu_req_d;
    logic             exu_req_q, exu_req_d;
    logic             core_wfi_q, core_wfi_d;
    logic             busy_q, busy_d;
    logic             wake_pls_q, wake_pls_d;
    logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;

    logic wake_evt;
    logic wake;
    logic ifu_ack_now;
    logic exu_ack_now;

`ifdef E203_WFI_EVT_WAKE_EN
    assign wake_evt = |evt_r;
`else
    assign wake_evt = 1'b0;
`endif

    // mstatus.MIE intentionally absent: WFI resumes even with global interrupts off.
    assign wake = dbg_irq_r | dbg_halt_r
                | (ext_irq_r & meie_r)
                | (sft_irq_r & msie_r)
                | (tmr_irq_r & mtie_r)
                | (|lcl_irq_r)
                | wake_evt;

    assign ifu_ack_now = ifu_ack_q | wfi_halt_ifu_ack;
    assign exu_ack_now = exu_ack_q | wfi_halt_exu_ack;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wfi_cmt && !dbg_mode) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wake) begin
                    state_d = ST_IDLE;
                end else if (oitf_empty && !pipe_flush_req) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wake) begin
                    state_d = ST_IDLE;
                end else if (ifu_ack_now && exu_ack_now) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (wake) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ack flags live only while REQ persists; any exit (sleep or abort) clears them.
    always_comb begin
        ifu_ack_d = 1'b0;
        exu_ack_d = 1'b0;
        if (state_q == ST_REQ && state_d == ST_REQ) begin
            ifu_ack_d = ifu_ack_now;
            exu_ack_d = exu_ack_now;
        end
    end

    always_comb begin
        ifu_req_d  = (state_d == ST_REQ) || (state_d == ST_SLEEP);
        exu_req_d  = (state_d == ST_REQ) || (state_d == ST_SLEEP);
        core_wfi_d = (state_d == ST_SLEEP);
        busy_d     = (state_d != ST_IDLE);
        wake_pls_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    always_comb begin
        sleep_cnt_d = sleep_cnt_q;
        if (state_q == ST_SLEEP) begin
            if (sleep_cnt_q != CNT_MAX) begin
                sleep_cnt_d = sleep_cnt_q + CNT_ONE;
            end
        end else if (state_d == ST_SLEEP) begin
            sleep_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ifu_ack_q   <= 1'b0;
            exu_ack_q   <= 1'b0;
            ifu_req_q   <= 1'b0;
            exu_req_q   <= 1'b0;
            core_wfi_q  <= 1'b0;
            busy_q      <= 1'b0;
            wake_pls_q  <= 1'b0;
            sleep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ifu_ack_q   <= ifu_ack_d;
            exu_ack_q   <= exu_ack_d;
            ifu_req_q   <= ifu_req_d;
            exu_req_q   <= exu_req_d;
            core_wfi_q  <= core_wfi_d;
            busy_q      <= busy_d;
            wake_pls_q  <= wake_pls_d;
            sleep_cnt_q <= sleep_cnt_d;
        end
    end

    assign wfi_halt_ifu_req = ifu_req_q;
    assign wfi_halt_exu_req = exu_req_q;
    assign core_wfi         = core_wfi_q;
    assign wfi_busy         = busy_q;
    assign wfi_wake         = wake_pls_q;
    assign sleep_cnt        = sleep_cnt_q;

`ifndef SYNTHESIS
    // Halt requests and a newly raised flush must never overlap.
    a_no_flush_in_halt: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(((state_q == ST_REQ) || (state_q == ST_SLEEP)) && $rose(pipe_flush_req))
    );
`endif

endmodule

// File: tb/tb_e203_exu_wfi_ctrl.sv
// Directed bench for e203_exu_wfi_ctrl; expected values are hand-derived cycle by cycle.
`timescale 1ns/1ps

module tb_e203_exu_wfi_ctrl;

    localparam int LIRQ_NUM = 2;
    localparam int EVT_NUM  = 2;
    localparam int CNT_W    = 32;

    logic                clk;
    logic                rst_n;
    logic                wfi_cmt, dbg_mode, dbg_halt_r, dbg_irq_r;
    logic                ext_irq_r, sft_irq_r, tmr_irq_r;
    logic                meie_r, msie_r, mtie_r;
    logic [LIRQ_NUM-1:0] lcl_irq_r;
    logic [EVT_NUM-1:0]  evt_r;
    logic                oitf_empty, pipe_flush_req;
    logic                wfi_halt_ifu_req, wfi_halt_exu_req;
    logic                wfi_halt_ifu_ack, wfi_halt_exu_ack;
    logic                core_wfi, wfi_busy, wfi_wake;
    logic [CNT_W-1:0]    sleep_cnt;

    int n_cmp;
    int n_err;

    e203_exu_wfi_ctrl #(
        .LIRQ_NUM(LIRQ_NUM),
        .EVT_NUM (EVT_NUM),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wfi_cmt          (wfi_cmt),
        .dbg_mode         (dbg_mode),
        .dbg_halt_r       (dbg_halt_r),
        .dbg_irq_r        (dbg_irq_r),
        .ext_irq_r        (ext_irq_r),
        .sft_irq_r        (sft_irq_r),
        .tmr_irq_r        (tmr_irq_r),
        .meie_r           (meie_r),
        .msie_r           (msie_r),
        .mtie_r           (mtie_r),
        .lcl_irq_r        (lcl_irq_r),
        .evt_r            (evt_r),
        .oitf_empty       (oitf_empty),
        .pipe_flush_req   (pipe_flush_req),
        .wfi_halt_ifu_req (wfi_halt_ifu_req),
        .wfi_halt_exu_req (wfi_halt_exu_req),
        .wfi_halt_ifu_ack (wfi_halt_ifu_ack),
        .wfi_halt_exu_ack (wfi_halt_exu_ack),
        .core_wfi         (core_wfi),
        .wfi_busy         (wfi_busy),
        .wfi_wake         (wfi_wake),
        .sleep_cnt        (sleep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to 1ns after the next rising edge: registered outputs are settled, new inputs apply to this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_evt_wake;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        {wfi_cmt, dbg_mode, dbg_halt_r, dbg_irq_r} = '0;
        {ext_irq_r, sft_irq_r, tmr_irq_r, meie_r, msie_r, mtie_r} = '0;
        lcl_irq_r = '0;
        evt_r = '0;
        oitf_empty = 1'b1;
        pipe_flush_req = 1'b0;
        wfi_halt_ifu_ack = 1'b0;
        wfi_halt_exu_ack = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ifu_req", 64'(wfi_halt_ifu_req), 64'd0);
        check("rst_exu_req", 64'(wfi_halt_exu_req), 64'd0);
        check("rst_core_wfi", 64'(core_wfi), 64'd0);
        check("rst_busy", 64'(wfi_busy), 64'd0);
        check("rst_wake", 64'(wfi_wake), 64'd0);
        check("rst_cnt", 64'(sleep_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic sleep and wake: cmt at T0
        wfi_cmt = 1'b1;
        tick();                                  // T0+1
        wfi_cmt = 1'b0;
        check("basic_busy_t1", 64'(wfi_busy), 64'd1);
        check("basic_req_t1", 64'(wfi_halt_ifu_req), 64'd0);
        tick();                                  // T0+2
        check("basic_ifu_req_t2", 64'(wfi_halt_ifu_req), 64'd1);
        check("basic_exu_req_t2", 64'(wfi_halt_exu_req), 64'd1);
        check("basic_core_t2", 64'(core_wfi), 64'd0);
        wfi_halt_ifu_ack = 1'b1;
        wfi_halt_exu_ack = 1'b1;
        tick();                                  // T0+3
        check("basic_core_t3", 64'(core_wfi), 64'd1);
        repeat (7) tick();                       // T0+10
        check("basic_core_t10", 64'(core_wfi), 64'd1);
        check("basic_req_t10", 64'(wfi_halt_exu_req), 64'd1);
        check("basic_wake_t10", 64'(wfi_wake), 64'd0);
        tmr_irq_r = 1'b1;
        mtie_r = 1'b1;
        tick();                                  // T0+11
        check("basic_wake_t11", 64'(wfi_wake), 64'd1);
        check("basic_req_t11", 64'(wfi_halt_ifu_req), 64'd0);
        check("basic_core_t11", 64'(core_wfi), 64'd0);
        check("basic_busy_t11", 64'(wfi_busy), 64'd0);
        check("basic_cnt_t11", 64'(sleep_cnt), 64'd8);
        tmr_irq_r = 1'b0;
        mtie_r = 1'b0;
        wfi_halt_ifu_ack = 1'b0;
        wfi_halt_exu_ack = 1'b0;
        tick();
        check("basic_wake_t12", 64'(wfi_wake), 64'd0);
        check("basic_cnt_hold", 64'(sleep_cnt), 64'd8);

        // Drain wait: oitf busy T0+1..T0+5, flush in the cycle it empties
        oitf_empty = 1'b0;
        wfi_cmt = 1'b1;
        tick();                                  // T0+1
        wfi_cmt = 1'b0;
        repeat (4) tick();                       // T0+5
        check("drain_req_t5", 64'(wfi_halt_ifu_req), 64'd0);
        check("drain_busy_t5", 64'(wfi_busy), 64'd1);
        tick();                                  // T0+6
        oitf_empty = 1'b1;
        pipe_flush_req = 1'b1;
        check("drain_req_t6", 64'(wfi_halt_ifu_req), 64'd0);
        tick();                                  // T0+7
        pipe_flush_req = 1'b0;
        check("drain_req_t7_flush", 64'(wfi_halt_ifu_req), 64'd0);
        tick();                                  // T0+8 = REQ
        check("drain_req_t8", 64'(wfi_halt_ifu_req), 64'd1);

        // Split acks: IFU at REQ+1, EXU at REQ+4, sleep at REQ+5
        tick();                                  // REQ+1
        wfi_halt_ifu_ack = 1'b1;
        check("split_core_r1", 64'(core_wfi), 64'd0);
        repeat (2) tick();                       // REQ+3
        check("split_core_r3", 64'(core_wfi), 64'd0);
        tick();                                  // REQ+4
        wfi_halt_exu_ack = 1'b1;
        check("split_core_r4", 64'(core_wfi), 64'd0);
        tick();                                  // REQ+5
        check("split_core_r5", 64'(core_wfi), 64'd1);
        wfi_halt_ifu_ack = 1'b0;
        wfi_halt_exu_ack = 1'b0;
        dbg_irq_r = 1'b1;
        tick();
        dbg_irq_r = 1'b0;
        check("split_wake", 64'(wfi_wake), 64'd1);
        check("split_cnt", 64'(sleep_cnt), 64'd1);
        tick();

        // Abort in REQ with only the IFU ack seen
        wfi_cmt = 1'b1;
        tick();
        wfi_cmt = 1'b0;
        tick();                                  // REQ
        wfi_halt_ifu_ack = 1'b1;
        tick();                                  // REQ+1, ifu flag set
        check("abort_req_pre", 64'(wfi_halt_ifu_req), 64'd1);
        check("abort_core_pre", 64'(core_wfi), 64'd0);
        wfi_halt_ifu_ack = 1'b0;
        ext_irq_r = 1'b1;
        meie_r = 1'b1;
        tick();
        ext_irq_r = 1'b0;
        meie_r = 1'b0;
        check("abort_req", 64'(wfi_halt_ifu_req), 64'd0);
        check("abort_core", 64'(core_wfi), 64'd0);
        check("abort_wake", 64'(wfi_wake), 64'd1);
        tick();
        // New sequence: a stale IFU flag would let EXU ack alone reach SLEEP
        wfi_cmt = 1'b1;
        tick();
        wfi_cmt = 1'b0;
        tick();                                  // REQ
        wfi_halt_exu_ack = 1'b1;
        tick();
        check("abort_flag_clear", 64'(core_wfi), 64'd0);
        wfi_halt_ifu_ack = 1'b1;
        tick();
        check("abort_resleep", 64'(core_wfi), 64'd1);
        wfi_halt_ifu_ack = 1'b0;
        wfi_halt_exu_ack = 1'b0;

        // Masked software interrupt must not wake
        sft_irq_r = 1'b1;
        msie_r = 1'b0;
        repeat (3) tick();
        check("masked_sft_core", 64'(core_wfi), 64'd1);
        sft_irq_r = 1'b0;

        // Event wake depends on configuration
`ifdef E203_WFI_EVT_WAKE_EN
        exp_evt_wake = 1'b1;
`else
        exp_evt_wake = 1'b0;
`endif
        evt_r = 2'b01;
        tick();
        evt_r = '0;
        check("evt_core", 64'(core_wfi), 64'(!exp_evt_wake));
        check("evt_wake", 64'(wfi_wake), 64'(exp_evt_wake));
        lcl_irq_r = 2'b10;
        tick();
        lcl_irq_r = '0;
        check("lcl_core", 64'(core_wfi), 64'd0);
        check("lcl_wake", 64'(wfi_wake), 64'(!exp_evt_wake));
        tick();

        // Debug mode: WFI is a NOP
        dbg_mode = 1'b1;
        wfi_cmt = 1'b1;
        tick();
        wfi_cmt = 1'b0;
        check("dbg_busy1", 64'(wfi_busy), 64'd0);
        tick();
        check("dbg_busy2", 64'(wfi_busy), 64'd0);
        dbg_mode = 1'b0;

        // Asynchronous reset mid-SLEEP
        wfi_cmt = 1'b1;
        tick();
        wfi_cmt = 1'b0;
        tick();
        wfi_halt_ifu_ack = 1'b1;
        wfi_halt_exu_ack = 1'b1;
        tick();
        check("rst_mid_core_pre", 64'(core_wfi), 64'd1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_core", 64'(core_wfi), 64'd0);
        check("rst_mid_req", 64'(wfi_halt_ifu_req), 64'd0);
        check("rst_mid_busy", 64'(wfi_busy), 64'd0);
        check("rst_mid_cnt", 64'(sleep_cnt), 64'd0);
        wfi_halt_ifu_ack = 1'b0;
        wfi_halt_exu_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_idle", 64'(wfi_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
